// File: rtl/usbdev_wake_tx.sv
// rtl/usbdev_wake_tx.sv - USB device remote-wakeup K-state generator
// Define USBDEV_WAKE_HOST_TIMEOUT_EN to give up in Await after HostTimeoutUs without host takeover.
module usbdev_wake_tx #(
  parameter logic [13:0] IdleMinUs     = 14'd2000,
  parameter logic [13:0] DriveUs       = 14'd2000,
  parameter logic [13:0] HostTimeoutUs = 14'd1000
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_ni,
  input  logic       us_tick_i,
  input  logic       link_suspend_i,
  input  logic       wake_en_i,
  input  logic       wake_req_i,
  output logic       wake_oe_o,
  output logic       wake_dp_o,
  output logic       wake_dn_o,
  output logic       wake_busy_o,
  output logic       wake_done_o,
  output logic       wake_abort_o,
  output logic       wake_reject_o,
  output logic       wake_fail_o,
  output logic [1:0] wake_state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPend  = 2'd1,
    StDrive = 2'd2,
    StAwait = 2'd3
  } state_e;

`ifdef USBDEV_WAKE_HOST_TIMEOUT_EN
  localparam bit HostTimeoutEn = 1'b1;
`else
  localparam bit HostTimeoutEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [13:0] dwell_q;
  logic [13:0] timer_q;
  logic        dwell_ok;
  logic        drive_tc;
  logic        host_tc;

  assign dwell_ok = (dwell_q == IdleMinUs);
  assign drive_tc = us_tick_i && (timer_q == DriveUs - 14'd1);
  assign host_tc  = HostTimeoutEn && us_tick_i && (timer_q == HostTimeoutUs - 14'd1);

  // Suspend dwell runs regardless of FSM state so a request can be granted immediately.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dwell_q <= '0;
    end else if (!link_suspend_i) begin
      dwell_q <= '0;
    end else if (us_tick_i && !dwell_ok) begin
      dwell_q <= dwell_q + 14'd1;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if (us_tick_i) begin
      timer_q <= timer_q + 14'd1;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wake_oe_o     = 1'b0;
    wake_dn_o     = 1'b0;
    wake_done_o   = 1'b0;
    wake_abort_o  = 1'b0;
    wake_reject_o = 1'b0;
    wake_fail_o   = 1'b0;
    case (state_q)
      StIdle: begin
        if (wake_req_i) begin
          if (wake_en_i && link_suspend_i) state_d = StPend;
          else                             wake_reject_o = 1'b1;
        end
      end
      StPend: begin
        if (!link_suspend_i || !wake_en_i) begin
          state_d      = StIdle;
          wake_abort_o = 1'b1;
        end else if (dwell_ok) begin
          state_d = StDrive;
        end
      end
      // Our own K disturbs the link detector, so suspend/enable are not looked at here.
      StDrive: begin
        wake_oe_o = 1'b1;
        wake_dn_o = 1'b1;
        if (drive_tc) state_d = StAwait;
      end
      StAwait: begin
        if (!link_suspend_i) begin
          state_d     = StIdle;
          wake_done_o = 1'b1;
        end else if (host_tc) begin
          state_d     = StIdle;
          wake_fail_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wake_dp_o    = 1'b0;
  assign wake_busy_o  = (state_q != StIdle);
  assign wake_state_o = state_q;

endmodule

// File: tb/tb_usbdev_wake_tx.sv
// tb/tb_usbdev_wake_tx.sv - scoreboard bench for usbdev_wake_tx with scaled timing parameters
`timescale 1ns/1ps
module tb_usbdev_wake_tx;

  localparam int T = 3;   // clock cycles per us tick
  localparam int I = 40;  // IdleMinUs
  localparam int D = 50;  // DriveUs
  localparam int H = 30;  // HostTimeoutUs

  localparam int EV_REJ  = 0;
  localparam int EV_ABT  = 1;
  localparam int EV_RISE = 2;
  localparam int EV_FALL = 3;
  localparam int EV_DONE = 4;
  localparam int EV_FAIL = 5;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       us_tick;
  logic       link_suspend;
  logic       wake_en;
  logic       wake_req;
  logic       oe, dp, dn, busy, done_p, abort_p, reject_p, fail_p;
  logic [1:0] state;

  int  total = 0;
  int  bad = 0;
  int  edge_n = 0;
  bit  prev_oe = 1'b0;
  ev_t sb[$];

  usbdev_wake_tx #(
    .IdleMinUs    (14'd40),
    .DriveUs      (14'd50),
    .HostTimeoutUs(14'd30)
  ) dut (
    .clk_48mhz_i   (clk),
    .rst_ni        (rst_ni),
    .us_tick_i     (us_tick),
    .link_suspend_i(link_suspend),
    .wake_en_i     (wake_en),
    .wake_req_i    (wake_req),
    .wake_oe_o     (oe),
    .wake_dp_o     (dp),
    .wake_dn_o     (dn),
    .wake_busy_o   (busy),
    .wake_done_o   (done_p),
    .wake_abort_o  (abort_p),
    .wake_reject_o (reject_p),
    .wake_fail_o   (fail_p),
    .wake_state_o  (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected nothing", kind, edge_n);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.at != edge_n) begin
        bad++;
        $display("FAIL event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                 kind, edge_n, e.kind, e.at);
      end
    end
  endtask

  // Monitor: samples on the falling edge; edge_n is the rising edge these inputs will meet.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_oe = 1'b0;
    end else begin
      if (reject_p)          observe(EV_REJ);
      if (abort_p)           observe(EV_ABT);
      if (oe && !prev_oe)    observe(EV_RISE);
      if (!oe && prev_oe)    observe(EV_FALL);
      if (done_p)            observe(EV_DONE);
      if (fail_p)            observe(EV_FAIL);
      prev_oe = oe;
      chk("dp_zero", int'(dp), 0);
      chk("dn_follows_oe", int'(dn), int'(oe));
      if (oe) chk("oe_only_in_drive", int'(state), 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    us_tick  = (edge_n % T == 0);
    wake_req = 1'b0;
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) step();
  endtask

  // Edge of the n-th tick at or after edge s.
  function automatic int nth_tick(input int s, input int n);
    return ((s + T - 1) / T) * T + (n - 1) * T;
  endfunction

  task automatic quiet();
    link_suspend = 1'b0;
    wake_en      = 1'b0;
    repeat (4) step();
    chk("queue_drained", sb.size(), 0);
    sb.delete();
  endtask

  // mode 0: drop suspend in Await, 1: drop suspend/en mid-Drive,
  // 2: hold suspend past host timeout, 3: drop suspend on the timeout edge
  task automatic wake_cycle(input int pre, input int mode);
    int s, r, dw, x, y, z, q;
    link_suspend = 1'b1;
    wake_en      = 1'b1;
    s = edge_n;
    repeat (pre) step();
    r  = edge_n;
    wake_req = 1'b1;
    dw = nth_tick(s, I);
    x  = (r + 1 > dw + 1) ? r + 1 : dw + 1;
    y  = nth_tick(x + 1, D);
    z  = nth_tick(y + 1, H);
    push(EV_RISE, x + 1);
    push(EV_FALL, y + 1);
    step();
    chk("pend_state", int'(state), 1);
    chk("pend_busy", int'(busy), 1);
    step_to(x + 1);
    chk("drive_state", int'(state), 2);
    wake_req = 1'b1;
    if (mode == 1) begin
      step_to(nth_tick(x + 1, (D * 7) / 20));
      link_suspend = 1'b0;
      wake_en      = 1'b0;
      push(EV_DONE, y + 1);
      step_to(y + 2);
      chk("immune_idle", int'(state), 0);
    end else begin
      step_to(y + 1);
      chk("await_state", int'(state), 3);
      chk("await_busy", int'(busy), 1);
      wake_req = 1'b1;
      if (mode == 0) begin
        q = y + 1 + int'($urandom_range(0, (H - 2) * T));
        step_to(q);
        link_suspend = 1'b0;
        push(EV_DONE, q);
      end else if (mode == 3) begin
        step_to(z);
        link_suspend = 1'b0;
        push(EV_DONE, z);
      end else begin
`ifdef USBDEV_WAKE_HOST_TIMEOUT_EN
        push(EV_FAIL, z);
        step_to(z);
`else
        step_to(z + 4);
        chk("no_timeout_await", int'(state), 3);
        link_suspend = 1'b0;
        push(EV_DONE, edge_n);
`endif
      end
      step();
      chk("back_idle", int'(state), 0);
      chk("idle_busy", int'(busy), 0);
    end
    quiet();
  endtask

  task automatic reject_case(input bit susp, input bit en);
    link_suspend = susp;
    wake_en      = en;
    repeat (int'($urandom_range(1, 6))) step();
    wake_req = 1'b1;
    push(EV_REJ, edge_n);
    step();
    chk("reject_idle", int'(state), 0);
    quiet();
  endtask

  task automatic abort_case(input bit drop_en);
    int a;
    link_suspend = 1'b1;
    wake_en      = 1'b1;
    repeat (int'($urandom_range(1, 5))) step();
    wake_req = 1'b1;
    step();
    chk("abort_pend", int'(state), 1);
    a = edge_n + int'($urandom_range(0, 60));
    step_to(a);
    if (drop_en) wake_en = 1'b0;
    else         link_suspend = 1'b0;
    push(EV_ABT, a);
    step();
    chk("abort_idle", int'(state), 0);
    quiet();
  endtask

  task automatic reset_mid_drive();
    int s, r, x, y;
    link_suspend = 1'b1;
    wake_en      = 1'b1;
    s = edge_n;
    repeat ((I + 2) * T) step();
    r = edge_n;
    wake_req = 1'b1;
    x = r + 1;
    push(EV_RISE, x + 1);
    step_to(nth_tick(x + 1, D / 2));
    rst_ni = 1'b0;
    #1;
    chk("rst_oe_async", int'(oe), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    step();
    step();
    rst_ni = 1'b1;
    s = edge_n;
    wake_req = 1'b1;
    x = nth_tick(s, I) + 1;
    y = nth_tick(x + 1, D);
    push(EV_RISE, x + 1);
    push(EV_FALL, y + 1);
    push(EV_DONE, y + 1);
    step();
    chk("rst_repend", int'(state), 1);
    step_to(y + 1);
    link_suspend = 1'b0;
    step();
    chk("rst_final_idle", int'(state), 0);
    quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    us_tick      = 1'b1;
    link_suspend = 1'b0;
    wake_en      = 1'b0;
    wake_req     = 1'b0;
    repeat (3) step();
    chk("reset_oe", int'(oe), 0);
    chk("reset_dn", int'(dn), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_pulses", int'({done_p, abort_p, reject_p, fail_p}), 0);
    rst_ni = 1'b1;
    step();
    chk("post_reset_state", int'(state), 0);

    repeat (2) wake_cycle((I + 2) * T + int'($urandom_range(0, 30)), 0);
    repeat (2) wake_cycle(int'($urandom_range(1, (I / 2) * T)), 0);
    reject_case(1'b1, 1'b0);
    reject_case(1'b0, 1'b1);
    reject_case(1'b0, 1'b0);
    abort_case(1'b0);
    abort_case(1'b1);
    wake_cycle((I + 2) * T + int'($urandom_range(0, 10)), 1);
    reset_mid_drive();
    wake_cycle((I + 2) * T, 2);
    wake_cycle(int'($urandom_range(1, I * T)), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
